alu_vector_checker: RTL

//  Hardware successor to the simulation-only ALU vector bench: holds a loadable table of
//  {opcode,funct,add_rshift_type,A,B,REF} vectors and replays them into the ALUdec+ALU pair.

---
 rtl/alu_vector_checker.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_vector_checker.sv
// Replays a loadable table of ALU test vectors into an external ALUdec+ALU pair,
// compares the result after a fixed latency, and keeps pass/fail tallies plus the first failure.
//
// state | meaning
// IDLE  | waiting for start; table may be loaded
// RUN   | driving table[idx], comparing once per DUT_LAT+1 cycles
// DONE  | results held; pass valid; start re-runs
module alu_vector_checker #(
    parameter int DW           = 32,
    parameter int DEPTH        = 32,
    parameter int AW           = 5,
    parameter int DUT_LAT      = 0,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                load_en,
    input  logic [AW-1:0]       load_addr,
    input  logic [11+3*DW-1:0]  load_data,
    input  logic [AW:0]         num_vectors,
    input  logic                start,
    output logic [6:0]          opcode,
    output logic [2:0]          funct,
    output logic                add_rshift_type,
    output logic [DW-1:0]       A,
    output logic [DW-1:0]       B,
    input  logic [DW-1:0]       dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [AW:0]         pass_count,
    output logic [AW:0]         fail_count,
    output logic [AW-1:0]       fail_idx,
    output logic [DW-1:0]       fail_dut,
    output logic [DW-1:0]       fail_ref
);

    localparam int LW = 11 + 3*DW;
    localparam int WW = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;
    localparam logic [WW-1:0] WAIT_TC = WW'(DUT_LAT);
    localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   table_mem [DEPTH];
    logic [LW-1:0]   cur_entry;
    logic [DW-1:0]   cur_ref;
    logic [AW-1:0]   idx;
    logic [WW-1:0]   wait_cnt;
    logic [AW:0]     n_lat;
    logic [AW:0]     n_eff;
    logic            start_acc;
    logic            cmp_edge;
    logic            mismatch;
    logic            last_vec;

    // Table is deliberately not reset so a reset does not force a reload.
    always_ff @(posedge Clock) begin
        if (load_en && (state != RUN))
            table_mem[load_addr] <= load_data;
    end

    assign cur_entry = table_mem[idx];
    assign cur_ref   = cur_entry[DW-1:0];

    always_comb begin
        opcode          = '0;
        funct           = '0;
        add_rshift_type = 1'b0;
        A               = '0;
        B               = '0;
        if (state == RUN) begin
            opcode          = cur_entry[LW-1 -: 7];
            funct           = cur_entry[LW-8 -: 3];
            add_rshift_type = cur_entry[3*DW];
            A               = cur_entry[3*DW-1 -: DW];
            B               = cur_entry[2*DW-1 -: DW];
        end
    end

    assign n_eff     = (num_vectors > DEPTH_N) ? DEPTH_N : num_vectors;
    assign start_acc = start && (state != RUN);
    assign cmp_edge  = (state == RUN) && (wait_cnt == '0);
    assign mismatch  = (dut_out != cur_ref);
    assign last_vec  = ({1'b0, idx} == (n_lat - (AW+1)'(1)));

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_acc)
                    state_nxt = (n_eff == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cmp_edge && (last_vec || ((STOP_ON_FAIL != 0) && mismatch)))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // wait_cnt is a down-counter; the compare happens at its terminal count of zero.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            idx        <= '0;
            wait_cnt   <= '0;
            n_lat      <= '0;
            pass_count <= '0;
            fail_count <= '0;
            fail_idx   <= '0;
            fail_dut   <= '0;
            fail_ref   <= '0;
        end else if (start_acc) begin
            idx        <= '0;
            wait_cnt   <= WAIT_TC;
            n_lat      <= n_eff;
            pass_count <= '0;
            fail_count <= '0;
            fail_idx   <= '0;
            fail_dut   <= '0;
            fail_ref   <= '0;
        end else if (state == RUN) begin
            if (cmp_edge) begin
                wait_cnt <= WAIT_TC;
                idx      <= idx + AW'(1);
                if (mismatch) begin
                    fail_count <= fail_count + (AW+1)'(1);
                    if (fail_count == '0) begin
                        fail_idx <= idx;
                        fail_dut <= dut_out;
                        fail_ref <= cur_ref;
                    end
                end else begin
                    pass_count <= pass_count + (AW+1)'(1);
                end
            end else begin
                wait_cnt <= wait_cnt - WW'(1);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (fail_count == '0);

endmodule
